// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - instruction-field stream into the encoder/loader
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;

    modport master (
        output in_valid, in_op, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I field descriptions and writes them into instruction memory
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    instr_encoder_loader_if.slave bus,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [31:0]         enc;
    logic                legal;
    logic                accept;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    assign op  = bus.in_op;
    assign f3  = bus.in_funct3;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign imm = bus.in_imm;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (op)
            OP_R:      enc = {1'b0, bus.in_funct7b5, 5'b00000, rs2, rs1, f3, rd, op};
            OP_IMM: begin
                enc = {imm[11:0], rs1, f3, rd, op};
                // Shift-immediates carry the shift kind in funct7, not in the immediate.
                if (f3 == 3'b101)
                    enc[31:25] = {1'b0, bus.in_funct7b5, 5'b00000};
                else if (f3 == 3'b001)
                    enc[31:25] = 7'b0000000;
            end
            OP_LOAD:   enc = {imm[11:0], rs1, f3, rd, op};
            OP_JALR:   enc = {imm[11:0], rs1, 3'b000, rd, op};
            OP_STORE:  enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_LUI:    enc = {imm[31:12], rd, op};
            OP_JAL:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:   legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            bus.in_ready <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= count;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        if (count != '0) begin
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr;
                            imem_wdata <= enc;
                            addr       <= addr + 1'b1;
                            remaining  <= remaining - 1'b1;
                            if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                                state        <= FIN;
                                bus.in_ready <= 1'b0;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - table-driven scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] base_addr = '0;
    logic [6:0] count = '0;
    logic       imem_we;
    logic [5:0] imem_addr;
    logic [31:0] imem_wdata;
    logic       busy, done, err;

    instr_encoder_loader_if bus();

    instr_encoder_loader #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .bus(bus), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] word;
        int          cyc;
    } wr_t;

    vec_t tbl [14];
    vec_t bad;
    wr_t  q [$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    logic [5:0] exp_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (q.size() == 0) begin
                check("spurious_we", {31'd0, imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = q.pop_front();
                check("wr_addr", {26'd0, imem_addr}, {26'd0, e.addr});
                check("wr_data", imem_wdata, e.word);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.in_op = v.op; bus.in_funct3 = v.f3; bus.in_funct7b5 = v.f7b5;
        bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_imm = v.imm;
        bus.in_valid = 1'b1;
    endtask

    task automatic do_start(input logic [5:0] b, input logic [6:0] n);
        base_addr = b; count = n; exp_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input vec_t v, output int acc);
        drive(v);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready) break;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            acc = cyc;
            if (v.legal) begin
                q.push_back('{addr: exp_addr, word: v.word, cyc: acc + 1});
                exp_addr = exp_addr + 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_check(input int acc);
        bus.in_valid = 1'b0;
        check("done_early", {31'd0, done}, 32'd0);
        check("ready_fin", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("done_cycle", {31'd0, done}, 32'd1);
        check("done_lat", cyc, acc + 2);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("queue_empty", q.size(), 0);
    endtask

    task automatic run_transfer(input logic [5:0] b, input int lo, input int n);
        int acc;
        do_start(b, 7'(n));
        for (int i = lo; i < lo + n; i++) send(tbl[i], acc);
        finish_check(acc);
    endtask

    initial begin
        int acc;
        tbl[0]  = '{7'h33, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 32'h0,        1'b1, 32'h002081B3};
        tbl[1]  = '{7'h6F, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h8,        1'b1, 32'h008000EF};
        tbl[2]  = '{7'h23, 3'd2, 1'b0, 5'd31, 5'd2, 5'd5, 32'h8,        1'b1, 32'h00512423};
        tbl[3]  = '{7'h63, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3};
        tbl[4]  = '{7'h33, 3'd0, 1'b1, 5'd5,  5'd6, 5'd7, 32'h0,        1'b1, 32'h407302B3};
        tbl[5]  = '{7'h13, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093};
        tbl[6]  = '{7'h13, 3'd5, 1'b1, 5'd2,  5'd3, 5'd0, 32'h00000FE4, 1'b1, 32'h4041D113};
        tbl[7]  = '{7'h13, 3'd1, 1'b1, 5'd2,  5'd3, 5'd0, 32'h00000FE4, 1'b1, 32'h00419113};
        tbl[8]  = '{7'h03, 3'd2, 1'b0, 5'd4,  5'd1, 5'd0, 32'hFFFFFFF8, 1'b1, 32'hFF80A203};
        tbl[9]  = '{7'h67, 3'd3, 1'b0, 5'd1,  5'd5, 5'd0, 32'h4,        1'b1, 32'h004280E7};
        tbl[10] = '{7'h37, 3'd0, 1'b0, 5'd7,  5'd0, 5'd0, 32'h12345ABC, 1'b1, 32'h123453B7};
        tbl[11] = '{7'h63, 3'd1, 1'b0, 5'd0,  5'd1, 5'd2, 32'h11,       1'b1, 32'h00209863};
        tbl[12] = '{7'h6F, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFFDFF06F};
        tbl[13] = '{7'h23, 3'd2, 1'b0, 5'd0,  5'd2, 5'd1, 32'hFFFFFFFC, 1'b1, 32'hFE112E23};
        bad     = '{7'h0F, 3'd0, 1'b0, 5'd1,  5'd1, 5'd1, 32'h0,        1'b0, 32'h0};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_funct3 = '0; bus.in_funct7b5 = 1'b0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;

        #12;
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_addr", {26'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // start with in_valid already high: no accept while idle
        drive(tbl[0]);
        start = 1'b1; base_addr = 6'd0; count = 7'd2; exp_addr = 6'd0;
        check("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        send(tbl[0], acc);
        send(tbl[1], acc);
        finish_check(acc);

        run_transfer(6'd20, 2, 12);
        check("legal_no_err", {31'd0, err}, 32'd0);

        run_transfer(6'd62, 4, 3);

        // illegal opcode, with a start pulse while busy that must be ignored
        do_start(6'd30, 7'd2);
        start = 1'b1; base_addr = 6'd5; count = 7'd0;
        send(bad, acc);
        start = 1'b0;
        check("err_set", {31'd0, err}, 32'd1);
        send(tbl[0], acc);
        send(tbl[1], acc);
        finish_check(acc);
        check("err_sticky", {31'd0, err}, 32'd1);

        // count = 0
        do_start(6'd9, 7'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        check("c0_busy", {31'd0, busy}, 32'd1);
        check("c0_ready", {31'd0, bus.in_ready}, 32'd0);
        acc = cyc - 1;
        finish_check(acc);

        // reset right after an accept drops the in-flight write
        do_start(6'd10, 7'd3);
        drive(tbl[2]);
        check("pre_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        run_transfer(6'd40, 8, 2);

        repeat (3) @(negedge clk);
        check("final_queue", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the single-cycle controller's decode path: takes field-level instruction descriptions (op, funct3, funct7b5, rd, rs1, rs2, imm) and encodes them into RV32I words.
- Encodes the same formats the controller decodes: R, I, S, B, U, J.
- Writes the encoded words sequentially into instruction memory through its write port.
- Used as the program loader ahead of the core; transfers run under a start/count FSM with valid/ready input handshake.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; the address counter wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address.
- count  in  ADDR_W+1  number of legal instructions to write; 0 allowed.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block accepts fields this cycle.
- in_op  in  7  opcode.
- in_funct3  in  3  funct3.
- in_funct7b5  in  1  funct7 bit 5.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate as signed byte offset/value.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky illegal-opcode flag; cleared on accepted start.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata = 0; remaining = 0.
  - Reset mid-transfer aborts the transfer; the in-flight write is dropped.
- FSM states: IDLE, RUN, FIN, DONE.
  - IDLE: on start, latch addr=base_addr, remaining=count, clear err. Go to RUN if count!=0, else FIN.
  - start is ignored while busy.
  - RUN: in_ready = 1. Accept = in_valid && in_ready.
  - On a legal accept: register the encoded word. In the next cycle imem_we=1 with imem_addr=addr (1-cycle latency). Then addr = addr+1 mod 2^ADDR_W and remaining--. On the accept that makes remaining 0, go to FIN.
  - On an illegal accept: consumed, no write, addr and remaining unchanged, err=1.
  - FIN: in_ready=0; last write completes; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Timing: last accept at cycle t gives the write at t+1 and done at t+2. count=0 with start at t gives done at t+2.
- imem_we is high only in the cycle after a legal accept; back-to-back accepts produce back-to-back writes.
- Legal opcodes: 0110011 R, 0010011 I, 0000011 I, 1100111 I, 0100011 S, 1100011 B, 0110111 U, 1101111 J. All others are illegal.
- Encodings (bit ranges are of the output word):
  - R: {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}. Exceptions:
    - op 0010011 with funct3=101: bits 31:25 = {0,funct7b5,00000}, bits 24:20 = imm[4:0].
    - op 0010011 with funct3=001: bits 31:25 = 0.
    - op 1100111: funct3 forced to 000.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; imm[0] ignored.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; imm[0] ignored.
- Fields unused by a format are ignored. Immediates are truncated; no range error is raised.
- Simultaneous start and in_valid in IDLE: in_valid is not accepted (in_ready=0).

Test Plan:
- R/J encoding: start base=0, count=2; add x3,x1,x2 (op 0x33, f3 0, f7b5 0, rd 3, rs1 1, rs2 2), then jal x1,8 (op 0x6F, rd 1, imm 8) -> mem[0]=0x002081B3, mem[1]=0x008000EF; done two cycles after the second accept.
- S/B encoding: sw x5,8(x2) (op 0x23, f3 2, rs1 2, rs2 5, imm 8) -> 0x00512423. beq x0,x0,-4 (op 0x63, imm 0xFFFFFFFC) -> 0xFE000EE3.
- Wrap-around: base=62, count=3, three legal instructions with in_valid held high -> writes at addresses 62, 63, 0 on consecutive cycles; busy falls after the done pulse.
- Illegal opcode: count=2; stream op 0x0F, then two legal instructions -> err=1, no write for 0x0F, legal words at base and base+1, done asserted.
- count=0 and start ignored: start with count=0 -> no imem_we, done at t+2. A second start pulse while busy -> ignored.
- Reset mid-RUN: assert reset one cycle after an accept -> imem_we=0, busy=0, state IDLE immediately. After release, a new start behaves normally.
